// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned MAX_BURST_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Bits needed to index n items (minimum 1)
    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set req bit after last_idx.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_idx,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    int unsigned cand;

    // Search last_idx+1, last_idx+2, ... wrapping modulo NREQ; first hit wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_idx) + k) % NREQ;
            if (!valid && req[IW'(cand)]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst hold sharing the FIFO write port among NREQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    last,
    input  logic [NREQ*DW-1:0] wdata_in,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [DW-1:0]      fifo_wdata,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    gnt,
    output logic               busy
);

    localparam int unsigned IW = clog2w(NREQ);
    localparam int unsigned BW = clog2w(MAX_BURST);

    arb_state_e      state, state_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            busy_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic [IW-1:0]   last_idx, last_nxt;
    logic [IW-1:0]   g_idx, g_idx_nxt;

    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [DW-1:0]   lane [NREQ];
    logic            burst_end;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req      (req),
        .last_idx (last_idx),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    // Split the flat data bus into per-requester lanes
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            lane[i] = wdata_in[i*DW +: DW];
        end
    end

    // State register; reset leaves requester 0 with first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            last_idx <= IW'(NREQ - 1);
            g_idx    <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
            beat_cnt <= beat_nxt;
            last_idx <= last_nxt;
            g_idx    <= g_idx_nxt;
        end
    end

    // Next-state and write-port outputs
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        busy_nxt   = busy;
        beat_nxt   = beat_cnt;
        last_nxt   = last_idx;
        g_idx_nxt  = g_idx;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        ack        = '0;
        burst_end  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = BURST;
                    g_idx_nxt = pick_idx;
                    gnt_nxt   = NREQ'(1) << pick_idx;
                    busy_nxt  = 1'b1;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                fifo_wr    = req[g_idx] & ~fifo_full;
                fifo_wdata = lane[g_idx];
                ack        = fifo_wr ? gnt : '0;
                // A beat held back by fifo_full never ends the burst on last
                burst_end  = ~req[g_idx] |
                             (fifo_wr & (last[g_idx] | (beat_cnt == BW'(MAX_BURST - 1))));
                if (burst_end) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    last_nxt  = g_idx;
                    beat_nxt  = '0;
                end else if (fifo_wr) begin
                    beat_nxt = beat_cnt + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned OW        = 1 + DW + 2*NREQ + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    last;
    logic [NREQ*DW-1:0] wdata_in;
    logic               fifo_full;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_wdata;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    gnt;
    logic               busy;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .last       (last),
        .wdata_in   (wdata_in),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .ack        (ack),
        .gnt        (gnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who holds the port, beats written, who went last
    bit              m_busy;
    int              m_g;
    int              m_beats;
    int              m_last;
    logic [NREQ-1:0] refresh;

    logic [OW-1:0] got, want;

    task automatic model_reset();
        m_busy  = 0;
        m_g     = 0;
        m_beats = 0;
        m_last  = NREQ - 1;
        refresh = '0;
    endtask

    // Apply one clock edge of the arbitration rules
    task automatic model_step();
        bit wr;
        wr = m_busy && req[m_g] && !fifo_full;
        refresh = '0;
        if (m_busy) begin
            if (wr) begin
                m_beats++;
                refresh[m_g] = 1'b1;
            end
            if (!req[m_g] || (wr && (last[m_g] || m_beats == MAX_BURST))) begin
                m_busy = 0;
                m_last = m_g;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (!m_busy && req[c]) begin
                    m_busy  = 1;
                    m_g     = c;
                    m_beats = 0;
                end
            end
        end
    endtask

    // Drive inputs (at negedge); accepted lanes get fresh data
    task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic f);
        req       = r;
        last      = l;
        fifo_full = f;
        for (int i = 0; i < NREQ; i++) begin
            if (refresh[i]) wdata_in[i*DW +: DW] = DW'($urandom);
        end
        refresh = '0;
    endtask

    // Let combinational outputs settle, then capture DUT and model views
    task automatic settle();
        logic            e_wr;
        logic [NREQ-1:0] oh;
        #1;
        oh   = m_busy ? (NREQ'(1) << m_g) : NREQ'(0);
        e_wr = m_busy && req[m_g] && !fifo_full;
        want = {e_wr, (m_busy ? wdata_in[m_g*DW +: DW] : DW'(0)),
                (e_wr ? oh : NREQ'(0)), oh, m_busy};
        got  = {fifo_wr, fifo_wdata, ack, gnt, busy};
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive('0, '0, 1'b0);
        settle();
        n_cmp++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", got, OW'(0));
        end
        tick();
        rst_n = 1'b1;
        drive('0, '0, 1'b0);
        settle();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_idle: got %h want %h", got, want);
        end
        tick();
    endtask

    task automatic test_single_last();
        int acks;
        int ack_cyc[$];
        acks = 0;
        do_reset();
        for (int cyc = 0; cyc < 7; cyc++) begin
            drive((acks < 3) ? 4'b0001 : 4'b0000, (acks == 2) ? 4'b0001 : 4'b0000, 1'b0);
            settle();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL single_last cyc %0d: got %h want %h", cyc, got, want);
            end
            if (cyc == 0 || cyc == 1 || cyc == 4) begin
                n_cmp++;
                if (gnt !== ((cyc == 1) ? 4'b0001 : 4'b0000)) begin
                    n_err++;
                    $display("FAIL single_last_gnt cyc %0d: got %b want %b", cyc, gnt,
                             (cyc == 1) ? 4'b0001 : 4'b0000);
                end
            end
            if (ack[0]) begin
                acks++;
                ack_cyc.push_back(cyc);
            end
            tick();
        end
        n_cmp++;
        if (ack_cyc.size() != 3 || ack_cyc[0] != 1 || ack_cyc[2] != 3) begin
            n_err++;
            $display("FAIL single_last_acks: got %0d acks want 3 on cycles 1..3", ack_cyc.size());
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            settle();
            n_cmp++;
            if (got !== want || fifo_wr !== ((cyc % 2) == 1)) begin
                n_err++;
                $display("FAIL round_robin cyc %0d: got %h want %h", cyc, got, want);
            end
            for (int i = 0; i < NREQ; i++) if (ack[i]) order.push_back(i);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (order.size() <= i || order[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL round_robin_order %0d: got %0d want %0d", i,
                         (order.size() > i) ? order[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_max_burst();
        bit e_wr;
        do_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(4'b0010, 4'b0000, 1'b0);
            settle();
            e_wr = (cyc >= 1 && cyc <= MAX_BURST) || cyc >= MAX_BURST + 2;
            n_cmp++;
            if (got !== want || fifo_wr !== e_wr) begin
                n_err++;
                $display("FAIL max_burst cyc %0d: got %h wr %b want %h wr %b",
                         cyc, got, fifo_wr, want, e_wr);
            end
            if (cyc == MAX_BURST + 2) begin
                n_cmp++;
                if (gnt !== 4'b0010) begin
                    n_err++;
                    $display("FAIL max_burst_regrant: got %b want 0010", gnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        int  n_wr;
        bit  full;
        n_wr = 0;
        do_reset();
        for (int cyc = 0; cyc < 25; cyc++) begin
            full = (cyc >= 3 && cyc <= 7);
            drive(4'b0001, 4'b0000, full);
            settle();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL full_stall cyc %0d: got %h want %h", cyc, got, want);
            end
            if (full) begin
                n_cmp++;
                if (fifo_wr !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0001) begin
                    n_err++;
                    $display("FAIL full_hold cyc %0d: got wr %b ack %b gnt %b want 0 0000 0001",
                             cyc, fifo_wr, ack, gnt);
                end
            end
            if (cyc == 22) begin
                n_cmp++;
                if (busy !== 1'b0 || n_wr != MAX_BURST) begin
                    n_err++;
                    $display("FAIL full_beats: got busy %b writes %0d want 0 %0d",
                             busy, n_wr, MAX_BURST);
                end
            end
            if (fifo_wr) n_wr++;
            tick();
        end
    endtask

    task automatic test_withdraw(input bit other3);
        int              n_ack;
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] next_g;
        n_ack  = 0;
        next_g = other3 ? 4'b1000 : 4'b0001;
        do_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            r = '0;
            r[2] = (n_ack < 2);
            r[3] = other3;
            r[0] = !other3 && (n_ack >= 2);
            drive(r, 4'b0000, 1'b0);
            settle();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL withdraw cyc %0d: got %h want %h", cyc, got, want);
            end
            if (cyc == 3) begin
                n_cmp++;
                if (fifo_wr !== 1'b0 || gnt !== 4'b0100) begin
                    n_err++;
                    $display("FAIL withdraw_drop: got wr %b gnt %b want 0 0100", fifo_wr, gnt);
                end
            end
            if (cyc == 5) begin
                n_cmp++;
                if (gnt !== next_g) begin
                    n_err++;
                    $display("FAIL withdraw_next: got %b want %b", gnt, next_g);
                end
            end
            if (ack[2]) n_ack++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b1111, 4'b0000, 1'b0);
        tick();
        tick();
        drive(4'b1111, 4'b0000, 1'b0);
        settle();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || fifo_wr !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got gnt %b busy %b wr %b want 0000 0 0", gnt, busy, fifo_wr);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 4'b0000, 1'b0);
        settle();
        tick();
        drive(4'b1111, 4'b0000, 1'b0);
        settle();
        n_cmp++;
        if (gnt !== 4'b0001 || got !== want) begin
            n_err++;
            $display("FAIL async_reset_regrant: got gnt %b want 0001", gnt);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] l;
        r = '0;
        l = '0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r[i] || refresh[i]) begin
                    r[i] = ($urandom_range(0, 99) < 60);
                    l[i] = ($urandom_range(0, 3) == 0);
                end else if ($urandom_range(0, 99) < 3) begin
                    r[i] = 1'b0;
                end
            end
            drive(r, l, $urandom_range(0, 4) == 0);
            settle();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, got, want);
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        wdata_in  = {$urandom, $urandom};
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_last();
        test_round_robin();
        test_max_burst();
        test_full_stall();
        test_withdraw(1'b1);
        test_withdraw(1'b0);
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
